// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - instruction handshake and ALU-facing bus for alu_issue_ctrl
interface alu_issue_ctrl_if #(
  parameter int N = 8
);
  // Instruction handshake from the upstream stage
  logic         instr_valid;
  logic         instr_ready;
  logic [15:0]  instr;

  // Issue signals to the ALU and its registered result back
  logic         alu_enable;
  logic [2:0]   alu_mode;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [N-1:0] alu_result;
  logic         alu_carry;

  // Environment side: offers instructions and returns ALU results
  modport master (
    output instr_valid,
    output instr,
    output alu_result,
    output alu_carry,
    input  instr_ready,
    input  alu_enable,
    input  alu_mode,
    input  alu_a,
    input  alu_b
  );

  // Controller side
  modport slave (
    input  instr_valid,
    input  instr,
    input  alu_result,
    input  alu_carry,
    output instr_ready,
    output alu_enable,
    output alu_mode,
    output alu_a,
    output alu_b
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue/writeback controller with register file and flags for the 8-bit ALU
module alu_issue_ctrl #(
  parameter int N    = 8,
  parameter int NREG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_issue_ctrl_if.slave bus,
  output logic         flag_z,
  output logic         flag_c,
  output logic         done,
  output logic         illegal,
  input  logic [1:0]   dbg_addr,
  output logic [N-1:0] dbg_data
);

  localparam int AW = $clog2(NREG);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDI = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WB,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [N-1:0]    imm_q, imm_d;
  logic [N-1:0]    alu_a_q, alu_a_d;
  logic [N-1:0]    alu_b_q, alu_b_d;
  logic [2:0]      alu_mode_q, alu_mode_d;
  logic            flag_z_q, flag_z_d;
  logic            flag_c_q, flag_c_d;
  logic [N-1:0]    regs_q [NREG];

  logic            rf_we;
  logic [N-1:0]    rf_wdata;

  // Decoded fields of the instruction currently offered
  logic [2:0]      in_op;
  logic [AW-1:0]   in_rd;
  logic [AW-1:0]   in_ra;
  logic [AW-1:0]   in_rb;
  logic            accept;

  assign in_op  = bus.instr[15:13];
  assign in_rd  = AW'(bus.instr[12:11]);
  assign in_ra  = AW'(bus.instr[10:9]);
  assign in_rb  = AW'(bus.instr[8:7]);
  assign accept = bus.instr_valid && (state_q == S_IDLE);

  // State, latched instruction fields, ALU operand registers and flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_mode_q <= '0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      imm_q      <= imm_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_mode_q <= alu_mode_d;
      flag_z_q   <= flag_z_d;
      flag_c_q   <= flag_c_d;
    end
  end

  // Register file: single write port used only in the writeback state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (rf_we) begin
      regs_q[rd_q] <= rf_wdata;
    end
  end

  // Next-state logic: accept in IDLE, one issue cycle for ALU ops, then writeback
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    imm_d      = imm_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_mode_d = alu_mode_q;
    flag_z_d   = flag_z_q;
    flag_c_d   = flag_c_q;
    rf_we      = 1'b0;
    rf_wdata   = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = in_op;
          rd_d  = in_rd;
          imm_d = N'(bus.instr[7:0]);
          if (in_op <= OP_XOR) begin
            // Operands are captured here, so a later write to the same
            // register cannot disturb them.
            alu_a_d    = regs_q[in_ra];
            alu_b_d    = regs_q[in_rb];
            alu_mode_d = in_op;
            state_d    = S_ISSUE;
          end else if (in_op == OP_LDI) begin
            state_d = S_WB;
          end else begin
            state_d = S_ERR;
          end
        end
      end

      S_ISSUE: begin
        state_d = S_WB;
      end

      S_WB: begin
        rf_we = 1'b1;
        if (op_q == OP_LDI) begin
          rf_wdata = imm_q;
        end else begin
          // Zero is derived from the result here; the ALU's own zero
          // output is one cycle late for this writeback.
          rf_wdata = bus.alu_result;
          flag_z_d = (bus.alu_result == '0);
          flag_c_d = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? bus.alu_carry : 1'b0;
        end
        state_d = S_IDLE;
      end

      S_ERR: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.alu_enable  = (state_q == S_ISSUE);
  assign bus.alu_mode    = alu_mode_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;

  assign done     = (state_q == S_WB);
  assign illegal  = (state_q == S_ERR);
  assign flag_z   = flag_z_q;
  assign flag_c   = flag_c_q;
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed table-driven bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

  logic       clk;
  logic       rst_n;
  logic       flag_z, flag_c, done, illegal;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int errors = 0;
  int checks = 0;

  alu_issue_ctrl_if #(.N(8)) bus ();

  alu_issue_ctrl #(.N(8), .NREG(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .done     (done),
    .illegal  (illegal),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: registers its result at the end of the enable cycle
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.alu_result <= 8'h00;
      bus.alu_carry  <= 1'b0;
    end else if (bus.alu_enable) begin
      case (bus.alu_mode)
        3'd0: {bus.alu_carry, bus.alu_result} <= {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        3'd1: begin
          bus.alu_result <= bus.alu_a - bus.alu_b;
          bus.alu_carry  <= (bus.alu_a < bus.alu_b);
        end
        3'd2: begin bus.alu_result <= bus.alu_a & bus.alu_b; bus.alu_carry <= 1'b0; end
        3'd3: begin bus.alu_result <= bus.alu_a | bus.alu_b; bus.alu_carry <= 1'b0; end
        3'd4: begin bus.alu_result <= bus.alu_a ^ bus.alu_b; bus.alu_carry <= 1'b0; end
        default: begin bus.alu_result <= 8'h00; bus.alu_carry <= 1'b0; end
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] ra, input logic [1:0] rb);
    return {op, rd, ra, rb, 7'd0};
  endfunction

  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {3'd5, rd, 2'd0, 1'b0, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reg(input string name, input logic [1:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    chk(name, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for instr_ready, got 0 expected 1", name);
  endtask

  // Offer one instruction, then count busy cycles and output pulses until ready returns
  task automatic run(input logic [15:0] ins, output int busy, output int en_n,
                     output int dn, output int il);
    int g;
    busy = 0; en_n = 0; dn = 0; il = 0; g = 0;
    @(negedge clk);
    while (!bus.instr_ready && g < 10) begin
      @(negedge clk);
      g++;
    end
    if (!bus.instr_ready) timeout_fail("accept");
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    g = 0;
    while (!bus.instr_ready && g < 10) begin
      if (bus.alu_enable) en_n++;
      if (done) dn++;
      if (illegal) il++;
      busy++;
      @(negedge clk);
      g++;
    end
    if (!bus.instr_ready) timeout_fail("complete");
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [1:0]  addr;
    logic [7:0]  data;
    logic        z;
    logic        c;
    int          busy;
    int          en;
    int          dn;
    int          il;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  initial begin
    int b, e, d, il;
    logic [15:0] seq [4];
    int acyc [8];
    int dcyc [8];
    int na, nd, idx, cyc;
    bit adv;

    vecs[0]  = '{ldi(2'd1, 8'h05),            2'd1, 8'h05, 1'b0, 1'b0, 1, 0, 1, 0};
    vecs[1]  = '{ldi(2'd2, 8'h03),            2'd2, 8'h03, 1'b0, 1'b0, 1, 0, 1, 0};
    vecs[2]  = '{alu(3'd0, 2'd3, 2'd1, 2'd2), 2'd3, 8'h08, 1'b0, 1'b0, 2, 1, 1, 0};
    vecs[3]  = '{ldi(2'd1, 8'hFF),            2'd1, 8'hFF, 1'b0, 1'b0, 1, 0, 1, 0};
    vecs[4]  = '{ldi(2'd2, 8'h01),            2'd2, 8'h01, 1'b0, 1'b0, 1, 0, 1, 0};
    vecs[5]  = '{alu(3'd0, 2'd0, 2'd1, 2'd2), 2'd0, 8'h00, 1'b1, 1'b1, 2, 1, 1, 0};
    vecs[6]  = '{alu(3'd2, 2'd3, 2'd1, 2'd1), 2'd3, 8'hFF, 1'b0, 1'b0, 2, 1, 1, 0};
    vecs[7]  = '{ldi(2'd1, 8'h02),            2'd1, 8'h02, 1'b0, 1'b0, 1, 0, 1, 0};
    vecs[8]  = '{alu(3'd1, 2'd3, 2'd2, 2'd1), 2'd3, 8'hFF, 1'b0, 1'b1, 2, 1, 1, 0};
    vecs[9]  = '{alu(3'd4, 2'd1, 2'd1, 2'd1), 2'd1, 8'h00, 1'b1, 1'b0, 2, 1, 1, 0};
    vecs[10] = '{alu(3'd6, 2'd2, 2'd0, 2'd0), 2'd2, 8'h01, 1'b1, 1'b0, 1, 0, 0, 1};
    vecs[11] = '{alu(3'd7, 2'd1, 2'd2, 2'd3), 2'd1, 8'h00, 1'b1, 1'b0, 1, 0, 0, 1};
    vecs[12] = '{ldi(2'd3, 8'h00),            2'd3, 8'h00, 1'b1, 1'b0, 1, 0, 1, 0};
    vecs[13] = '{alu(3'd3, 2'd2, 2'd2, 2'd0), 2'd2, 8'h01, 1'b0, 1'b0, 2, 1, 1, 0};
    vecs[14] = '{alu(3'd1, 2'd0, 2'd2, 2'd2), 2'd0, 8'h00, 1'b1, 1'b0, 2, 1, 1, 0};
    vecs[15] = '{ldi(2'd0, 8'h7F),            2'd0, 8'h7F, 1'b1, 1'b0, 1, 0, 1, 0};
    vecs[16] = '{alu(3'd0, 2'd1, 2'd0, 2'd2), 2'd1, 8'h80, 1'b0, 1'b0, 2, 1, 1, 0};
    vecs[17] = '{ldi(2'd2, 8'h81),            2'd2, 8'h81, 1'b0, 1'b0, 1, 0, 1, 0};
    vecs[18] = '{alu(3'd0, 2'd3, 2'd1, 2'd2), 2'd3, 8'h01, 1'b0, 1'b1, 2, 1, 1, 0};
    vecs[19] = '{ldi(2'd0, 8'h00),            2'd0, 8'h00, 1'b0, 1'b1, 1, 0, 1, 0};

    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;
    dbg_addr = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("rst_flag_z", {31'd0, flag_z}, 32'd0);
    chk("rst_flag_c", {31'd0, flag_c}, 32'd0);
    chk("rst_alu_enable", {31'd0, bus.alu_enable}, 32'd0);
    chk("rst_alu_mode", {29'd0, bus.alu_mode}, 32'd0);
    chk("rst_alu_a", {24'd0, bus.alu_a}, 32'd0);
    chk("rst_alu_b", {24'd0, bus.alu_b}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    for (int r = 0; r < 4; r++) chk_reg($sformatf("rst_reg%0d", r), 2'(r), 8'h00);

    for (int i = 0; i < NV; i++) begin
      run(vecs[i].ins, b, e, d, il);
      chk($sformatf("v%0d_busy", i), b, vecs[i].busy);
      chk($sformatf("v%0d_alu_enable_cycles", i), e, vecs[i].en);
      chk($sformatf("v%0d_done_pulses", i), d, vecs[i].dn);
      chk($sformatf("v%0d_illegal_pulses", i), il, vecs[i].il);
      chk($sformatf("v%0d_flag_z", i), {31'd0, flag_z}, {31'd0, vecs[i].z});
      chk($sformatf("v%0d_flag_c", i), {31'd0, flag_c}, {31'd0, vecs[i].c});
      chk_reg($sformatf("v%0d_reg", i), vecs[i].addr, vecs[i].data);
    end

    // Reset asserted while an ADD is in its issue cycle aborts it
    run(ldi(2'd0, 8'h80), b, e, d, il);
    run(ldi(2'd1, 8'h80), b, e, d, il);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = alu(3'd0, 2'd2, 2'd0, 2'd1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("abort_in_issue", {31'd0, bus.alu_enable}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_flag_z", {31'd0, flag_z}, 32'd0);
    chk("abort_flag_c", {31'd0, flag_c}, 32'd0);
    chk("abort_alu_a", {24'd0, bus.alu_a}, 32'd0);
    chk("abort_alu_mode", {29'd0, bus.alu_mode}, 32'd0);
    chk_reg("abort_r2", 2'd2, 8'h00);
    chk_reg("abort_r0", 2'd0, 8'h00);
    repeat (2) @(negedge clk);
    chk_reg("abort_r2_late", 2'd2, 8'h00);

    // Valid held high across four instructions
    seq[0] = ldi(2'd1, 8'h03);
    seq[1] = alu(3'd0, 2'd2, 2'd1, 2'd1);
    seq[2] = alu(3'd0, 2'd3, 2'd2, 2'd1);
    seq[3] = ldi(2'd0, 8'h11);
    na = 0; nd = 0; idx = 0; cyc = 0; adv = 1'b0;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = seq[0];
    repeat (14) begin
      if (done && nd < 8) begin dcyc[nd] = cyc; nd++; end
      if (bus.instr_valid && bus.instr_ready && na < 8) begin
        acyc[na] = cyc; na++; adv = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (adv) begin
        adv = 1'b0;
        idx++;
        if (idx < 4) bus.instr = seq[idx];
        else bus.instr_valid = 1'b0;
      end
    end
    chk("b2b_accepts", na, 4);
    chk("b2b_dones", nd, 4);
    if (na == 4) begin
      chk("b2b_acc0", acyc[0], 0);
      chk("b2b_acc1", acyc[1], 2);
      chk("b2b_acc2", acyc[2], 5);
      chk("b2b_acc3", acyc[3], 8);
    end
    if (nd == 4) begin
      chk("b2b_done0", dcyc[0], 1);
      chk("b2b_done1", dcyc[1], 4);
      chk("b2b_done2", dcyc[2], 7);
      chk("b2b_done3", dcyc[3], 9);
    end
    chk_reg("b2b_r1", 2'd1, 8'h03);
    chk_reg("b2b_r2", 2'd2, 8'h06);
    chk_reg("b2b_r3", 2'd3, 8'h09);
    chk_reg("b2b_r0", 2'd0, 8'h11);
    chk("b2b_flag_z", {31'd0, flag_z}, 32'd0);
    chk("b2b_flag_c", {31'd0, flag_c}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
